// File: rtl/mem_wb_elastic.sv
// MEM/WB boundary register with valid/ready handshake, 2-entry skid buffer,
// flush and $zero write suppression. Define PIPE_STATS_EN to add stall/bubble counters.
module mem_wb_elastic #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_reg_wr,
  input  logic [ADDR_W-1:0] in_waddr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_reg_wr,
  output logic [ADDR_W-1:0] out_waddr,
`ifdef PIPE_STATS_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
`endif
  output logic              out_wr_en
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              reg_wr;
    logic [ADDR_W-1:0] waddr;
  } entry_t;

  if (DATA_W < 1 || ADDR_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("mem_wb_elastic: DATA_W, ADDR_W and CNT_W must be positive");
  end

  entry_t main_q, skid_q, in_e;
  logic   main_valid, skid_valid;
  logic   accept, pop;

  assign in_e   = '{data: in_data, reg_wr: in_reg_wr, waddr: in_waddr};
  // in_ready is the inverted skid flop, so nothing downstream reaches it combinationally
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign pop      = main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (accept) begin
        main_q     <= in_e;
        main_valid <= 1'b1;
      end
    end else if (pop) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q <= in_e;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= in_e;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid  = main_valid;
  assign out_data   = main_q.data;
  assign out_waddr  = main_q.waddr;
  assign out_reg_wr = main_valid & main_q.reg_wr;
  assign out_wr_en  = out_reg_wr & (main_q.waddr != '0);

`ifdef PIPE_STATS_EN
  // Counters survive flush; only rst clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_valid && !out_ready) stall_cnt <= stall_cnt + 1'b1;
      if (!main_valid) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_elastic.sv
// Scoreboard bench for mem_wb_elastic: an occupancy-limited FIFO model (capacity 2)
// predicts every output; directed scenarios followed by randomized traffic.
module tb_mem_wb_elastic;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, in_valid, in_ready, in_reg_wr;
  logic out_valid, out_ready, out_reg_wr, out_wr_en;
  logic [DATA_W-1:0] in_data, out_data;
  logic [ADDR_W-1:0] in_waddr, out_waddr;
`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;
  logic [CNT_W-1:0] m_stall = '0, m_bubble = '0;
`endif

  mem_wb_elastic #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_reg_wr(in_reg_wr), .in_waddr(in_waddr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_reg_wr(out_reg_wr), .out_waddr(out_waddr),
`ifdef PIPE_STATS_EN
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
    .out_wr_en(out_wr_en)
  );

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              rw;
    logic [ADDR_W-1:0] a;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_err = 0;
  bit   started = 1'b0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor + model: compare against the FIFO view, then apply this cycle's transfers.
  always @(negedge clk) begin
    bit   exp_v, exp_rdy, do_pop, do_push;
    ent_t f;
    exp_v   = (q.size() > 0);
    exp_rdy = (q.size() < 2);
    if (started) begin
      chk("out_valid", DATA_W'(out_valid), DATA_W'(exp_v));
      chk("in_ready", DATA_W'(in_ready), DATA_W'(exp_rdy));
      if (exp_v) begin
        f = q[0];
        chk("out_data", out_data, f.d);
        chk("out_waddr", DATA_W'(out_waddr), DATA_W'(f.a));
        chk("out_reg_wr", DATA_W'(out_reg_wr), DATA_W'(f.rw));
        chk("out_wr_en", DATA_W'(out_wr_en), DATA_W'(f.rw && f.a != 0));
      end else begin
        chk("idle_reg_wr", DATA_W'(out_reg_wr), '0);
        chk("idle_wr_en", DATA_W'(out_wr_en), '0);
      end
`ifdef PIPE_STATS_EN
      chk("stall_cnt", DATA_W'(stall_cnt), DATA_W'(m_stall));
      chk("bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(m_bubble));
`endif
    end
    do_pop  = exp_v && out_ready;
    do_push = in_valid && exp_rdy;
`ifdef PIPE_STATS_EN
    if (rst) begin
      m_stall = '0; m_bubble = '0;
    end else begin
      if (exp_v && !out_ready) m_stall++;
      if (!exp_v) m_bubble++;
    end
`endif
    if (rst || flush) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{d: in_data, rw: in_reg_wr, a: in_waddr});
    end
  end

  task automatic step(input bit iv, input logic [DATA_W-1:0] d, input bit rw,
                      input logic [ADDR_W-1:0] a, input bit ordy, input bit fl, input bit r);
    in_valid = iv; in_data = d; in_reg_wr = rw; in_waddr = a;
    out_ready = ordy; flush = fl; rst = r;
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit ordy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    step(1'b1, 64'h55, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    started = 1'b1;
    idle(1'b0, 3);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_waddr", DATA_W'(out_waddr), '0);
    chk("rst_wr_en", DATA_W'(out_wr_en), '0);

    // streaming with downstream always ready
    for (int i = 1; i <= 3; i++) step(1'b1, DATA_W'(i), 1'b1, ADDR_W'(7 + i), 1'b1, 1'b0, 1'b0);
    idle(1'b1, 2);

    // backpressure fills the skid
    step(1'b1, 64'hA, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hB, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hF, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 3);

    // write to $zero
    step(1'b1, 64'h77, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 2);

    // flush with both entries full and a same-cycle offer
    step(1'b1, 64'hD, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hE, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hC, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 2);

    // reset mid-stream with skid full
    step(1'b1, 64'h21, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h22, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h23, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 2);

    for (int i = 0; i < 3000; i++) begin
      logic [DATA_W-1:0] d;
      d = {$urandom, $urandom};
      step($urandom_range(0, 9) < 6, d, 1'(($urandom & 1)),
           ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom),
           $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0,
           $urandom_range(0, 149) == 0);
    end
    idle(1'b1, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
